// File: rtl/ad1_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the ad1 register file and its master.
// Member names follow the AXI channel signal names without the S_AXI_ prefix.
interface ad1_axil_slave_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/ad1_axil_slave_regs.sv
// AXI4-Lite slave register file: NREG byte-maskable 32-bit registers with
// independent write/read FSMs and a one-cycle write strobe per register.
module ad1_axil_slave_regs #(
    parameter int  C_S_AXI_DATA_WIDTH = 32,
    parameter int  C_S_AXI_ADDR_WIDTH = 4,
    localparam int NREG = 2 ** (C_S_AXI_ADDR_WIDTH - 2)
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    ad1_axil_slave_regs_if.slave               S_AXI,
    output logic [NREG*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NREG-1:0]                    reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]     aw_idx_q, aw_idx_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [NB-1:0]     w_strb_q, w_strb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [NREG-1:0]   pulse_q, pulse_d;
    logic              commit;

    rd_state_e         rd_state_q, rd_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [IW-1:0]     ar_idx;

    logic              unused_bits;
    assign unused_bits = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};

    // Commit happens on the edge where both halves are held, using the
    // address/data that may be arriving on that very edge.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        pulse_d    = '0;
        commit     = 1'b0;
        case (wr_state_q)
            WR_COLLECT: begin
                if (S_AXI.AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = S_AXI.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (S_AXI.WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    w_data_d = S_AXI.WDATA;
                    w_strb_d = S_AXI.WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    commit            = 1'b1;
                    pulse_d[aw_idx_d] = 1'b1;
                    aw_held_d         = 1'b0;
                    w_held_d          = 1'b0;
                    bvalid_d          = 1'b1;
                    wr_state_d        = WR_RESP;
                end
            end
            WR_RESP: begin
                if (S_AXI.BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = WR_COLLECT;
                end
            end
        endcase
        awready_d = (wr_state_d == WR_COLLECT) && !aw_held_d;
        wready_d  = (wr_state_d == WR_COLLECT) && !w_held_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WR_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            pulse_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            pulse_q    <= pulse_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DW-1:0] data_q;
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    data_q <= '0;
                end else if (commit && (aw_idx_d == IW'(gi))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_d[b]) data_q[8*b +: 8] <= w_data_d[8*b +: 8];
                    end
                end
            end
            assign reg_out[gi*DW +: DW] = data_q;
        end
    endgenerate

    // Read samples reg_out before this edge's commit lands, so a same-edge
    // collision returns the old contents.
    assign ar_idx = S_AXI.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (S_AXI.ARVALID && arready_q) begin
                    rdata_d    = reg_out[int'(ar_idx)*DW +: DW];
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (S_AXI.RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI.AWREADY = awready_q;
    assign S_AXI.WREADY  = wready_q;
    assign S_AXI.BVALID  = bvalid_q;
    assign S_AXI.BRESP   = 2'b00;
    assign S_AXI.ARREADY = arready_q;
    assign S_AXI.RVALID  = rvalid_q;
    assign S_AXI.RDATA   = rdata_q;
    assign S_AXI.RRESP   = 2'b00;
    assign reg_wr_pulse  = pulse_q;
endmodule
